ahblite_bus_fabric: RTL and testbench
=====================================

# ahblite_bus_fabric

Parametrised single-master AHB-Lite interconnect for the Cortex-M0 SoC, sitting between the core bus interface and NUM_SLAVES peripheral ports. It performs address-phase decode against per-slave base/mask windows and registers the data-phase slave select. It multiplexes HRDATA/HRESP/HREADY back to the core. An integrated default slave returns a two-cycle ERROR for unmapped accesses, and an optional watchdog terminates stalled transfers.

## Interface
- NUM_SLAVES, 7: number of slave ports, 1..16.
- DATA_W, 32: data bus width, 32 or 64.
- SLV_BASE, {NUM_SLAVES{32'h0}}: packed NUM_SLAVES*32 base addresses; slave i at bits [32*i+:32].
- SLV_MASK, {NUM_SLAVES{32'hF000_0000}}: packed NUM_SLAVES*32 decode masks.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles (used only with watchdog macro).
- HCLK  in  1  bus clock; sole clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE  in  32/3/1/4/3/2/1  master address phase.
- HWDATA  in  DATA_W  master write data.
- HREADY  out  1  transfer-complete to master; also broadcast to slaves.
- HRDATA  out  DATA_W  read data to master.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HSEL_S  out  NUM_SLAVES  one-hot address-phase select.
- HADDR_S, HBURST_S, HMASTLOCK_S, HPROT_S, HSIZE_S, HTRANS_S, HWRITE_S, HWDATA_S  out  as master  broadcast copies of master signals.
- HREADY_S  out  1  equals HREADY.
- HREADYOUT_S  in  NUM_SLAVES  per-slave ready.
- HRESP_S  in  NUM_SLAVES  per-slave response.
- HRDATA_S  in  NUM_SLAVES*DATA_W  packed read data.
- DEC_ERR  out  1  one-cycle pulse when the default slave completes an ERROR.
- WDT_ERR  out  1  one-cycle pulse on watchdog termination; tied 0 when compiled out.

## Operation
- Decode (combinational): slave i hits when (HADDR & SLV_MASK[i]) == SLV_BASE[i]. Lowest index wins on overlap. No hit selects the default slave. HSEL_S is driven irrespective of HTRANS.
- Data-phase select sel_q, one-hot over NUM_SLAVES+1 including the default slave: loads decode result when HREADY=1 and HTRANS[1]=1. Loads "none" when HREADY=1 and HTRANS is IDLE/BUSY. Holds when HREADY=0.
- Response mux:
  - sel_q = slave i: HREADY/HRESP/HRDATA taken from slave i.
  - sel_q = none: HREADY=1, HRESP=0, HRDATA=0.
  - sel_q = default: driven by the default-slave FSM, HRDATA=0.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE→ERR1 when a NONSEQ/SEQ is accepted with no decode hit.
  - ERR1 (HREADY=0, HRESP=1) → ERR2.
  - ERR2 (HREADY=1, HRESP=1; DEC_ERR=1) → ERR1 if another unmapped NONSEQ/SEQ is accepted, else IDLE.
- Back-to-back transfers to different slaves have no dead cycle.

## Timing
- Zero added wait states. HSEL_S is valid in the same cycle as HADDR, and the data-phase mux switches one cycle after address acceptance.
- Unmapped access: exactly one wait state, i.e. two cycles with HRESP=1.
- Reset values: sel_q=none, FSM=IDLE, watchdog counter=0. Outputs HREADY=1, HRESP=0, HRDATA=0, DEC_ERR=0, WDT_ERR=0. HSEL_S follows the combinational decode of HADDR.
- Reset asserted mid-transfer: state clears immediately. The stalled slave is not reissued anything.
- Master issuing a transfer during the ERR1 cycle violates AHB-Lite; the fabric ignores it (HREADY=0, so nothing is accepted).

## Configuration
- AHB_FABRIC_WATCHDOG_EN defined:
  - A counter increments each cycle while sel_q selects a real slave and its HREADYOUT=0.
  - The counter clears on HREADY=1.
  - When the count reaches TIMEOUT_CYCLES, the fabric overrides the slave response with the ERR1/ERR2 sequence, pulses WDT_ERR in ERR2, and clears sel_q.
- AHB_FABRIC_WATCHDOG_EN undefined: no counter, WDT_ERR tied 0, and a stalled slave stalls the bus indefinitely.

## Structure
- Package ahblite_fabric_pkg holds:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HRESP codes.
  - Default-slave state enum.
  - Helper function for watchdog counter width, $clog2(TIMEOUT_CYCLES+1).
- Sub-module ahblite_default_slave contains the ERR FSM and DEC_ERR. The watchdog reuses its ERR sequencing through a force input.

## Test plan
- NUM_SLAVES=3, bases 0x0000_0000 / 0x2000_0000 / 0x4000_0000, mask 0xF000_0000. NONSEQ read of 0x2000_0010 with slave 1 HRDATA=0xCAFE_F00D → HSEL_S=3'b010 in the address cycle; HRDATA=0xCAFE_F00D, HRESP=0 in the next cycle.
- NONSEQ write to 0x9000_0000 → HSEL_S=0; data cycle 1 gives HREADY=0, HRESP=1; cycle 2 gives HREADY=1, HRESP=1, DEC_ERR=1 pulse.
- Back-to-back read 0x0000_0004 then 0x4000_0008, slave 0 holding HREADYOUT=0 for 2 cycles → sel_q holds slave 0 for 3 cycles, then slave 2 data appears with no bubble.
- Overlapping windows (slave 0 mask 0x0000_0000) → any address selects slave 0 only.
- Watchdog macro on, TIMEOUT_CYCLES=8, slave 1 HREADYOUT stuck 0 → ERR1 at cycle 8 of the data phase, WDT_ERR pulse in ERR2, next transfer proceeds normally.
- HRESETn low during slave 1 wait state → HREADY=1, HRESP=0, sel_q=none on the following edge.

Source files
------------

// File: rtl/ahblite_bus_fabric_pkg.sv
// ahblite_fabric_pkg: shared definitions for the AHB-Lite bus fabric.
//   - HTRANS / HRESP encodings
//   - default-slave FSM state type
//   - watchdog counter width helper
package ahblite_fabric_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic {
        RespOkay  = 1'b0,
        RespError = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StErr1 = 2'b01,
        StErr2 = 2'b10
    } ds_state_e;

    localparam int unsigned MaxSlaves = 16;

    // Counter must be able to hold the value TIMEOUT_CYCLES itself.
    function automatic int unsigned wdt_cnt_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/ahblite_bus_fabric_if.sv
// ahblite_bus_fabric_if: bundle of every AHB-Lite signal around the fabric.
//   Upstream (core) side : HADDR..HWDATA in, HREADY/HRDATA/HRESP out.
//   Downstream side      : HSEL_S, broadcast HADDR_S..HWDATA_S, HREADY_S out;
//                          HREADYOUT_S, HRESP_S, HRDATA_S in.
//   Status               : DEC_ERR, WDT_ERR.
// modport slave  - the fabric's view (it is the slave of the core).
// modport master - the environment's view (core plus peripheral models).
interface ahblite_bus_fabric_if
    import ahblite_fabric_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 7,
    parameter int unsigned DATA_W     = 32
);
    // Core address/data phase
    logic [31:0]                  HADDR;
    logic [2:0]                   HBURST;
    logic                         HMASTLOCK;
    logic [3:0]                   HPROT;
    logic [2:0]                   HSIZE;
    logic [1:0]                   HTRANS;
    logic                         HWRITE;
    logic [DATA_W-1:0]            HWDATA;
    // Response to core
    logic                         HREADY;
    logic [DATA_W-1:0]            HRDATA;
    logic                         HRESP;
    // Slave-side broadcast
    logic [NUM_SLAVES-1:0]        HSEL_S;
    logic [31:0]                  HADDR_S;
    logic [2:0]                   HBURST_S;
    logic                         HMASTLOCK_S;
    logic [3:0]                   HPROT_S;
    logic [2:0]                   HSIZE_S;
    logic [1:0]                   HTRANS_S;
    logic                         HWRITE_S;
    logic [DATA_W-1:0]            HWDATA_S;
    logic                         HREADY_S;
    // Slave responses
    logic [NUM_SLAVES-1:0]        HREADYOUT_S;
    logic [NUM_SLAVES-1:0]        HRESP_S;
    logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S;
    // Status pulses
    logic                         DEC_ERR;
    logic                         WDT_ERR;

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
        output HREADY, HRDATA, HRESP,
        output HSEL_S, HADDR_S, HBURST_S, HMASTLOCK_S, HPROT_S, HSIZE_S, HTRANS_S,
        output HWRITE_S, HWDATA_S, HREADY_S,
        input  HREADYOUT_S, HRESP_S, HRDATA_S,
        output DEC_ERR, WDT_ERR
    );

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
        input  HREADY, HRDATA, HRESP,
        input  HSEL_S, HADDR_S, HBURST_S, HMASTLOCK_S, HPROT_S, HSIZE_S, HTRANS_S,
        input  HWRITE_S, HWDATA_S, HREADY_S,
        output HREADYOUT_S, HRESP_S, HRDATA_S,
        input  DEC_ERR, WDT_ERR
    );

endinterface

// File: rtl/ahblite_bus_fabric_default_slave.sv
// ahblite_default_slave: two-cycle ERROR responder for the bus fabric.
//   clk, rst_n  : clock, asynchronous active-low reset
//   err_start   : unmapped NONSEQ/SEQ accepted this cycle
//   force_err   : watchdog termination request (starts ERR sequence)
//   busy        : FSM is in ERR1 or ERR2, fabric must use ready/resp below
//   ready, resp : registered response (ERR1: 0/ERROR, ERR2: 1/ERROR)
//   dec_err     : pulse in ERR2 of a decode-error sequence
//   wdt_err     : pulse in ERR2 of a watchdog-termination sequence
module ahblite_default_slave
    import ahblite_fabric_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic err_start,
    input  logic force_err,
    output logic busy,
    output logic ready,
    output logic resp,
    output logic dec_err,
    output logic wdt_err
);

    ds_state_e state_q;
    logic      wdt_src_q;  // current ERR sequence was started by the watchdog

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wdt_src_q <= 1'b0;
            ready     <= 1'b1;
            resp      <= RespOkay;
            dec_err   <= 1'b0;
            wdt_err   <= 1'b0;
        end else begin
            dec_err <= 1'b0;
            wdt_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (force_err || err_start) begin
                        state_q   <= StErr1;
                        wdt_src_q <= force_err;
                        ready     <= 1'b0;
                        resp      <= RespError;
                    end
                end
                StErr1: begin
                    state_q <= StErr2;
                    ready   <= 1'b1;
                    resp    <= RespError;
                    dec_err <= ~wdt_src_q;
                    wdt_err <= wdt_src_q;
                end
                StErr2: begin
                    if (err_start) begin
                        state_q   <= StErr1;
                        wdt_src_q <= 1'b0;
                        ready     <= 1'b0;
                        resp      <= RespError;
                    end else begin
                        state_q   <= StIdle;
                        wdt_src_q <= 1'b0;
                        ready     <= 1'b1;
                        resp      <= RespOkay;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    wdt_src_q <= 1'b0;
                    ready     <= 1'b1;
                    resp      <= RespOkay;
                end
            endcase
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: rtl/ahblite_bus_fabric.sv
// ahblite_bus_fabric: single-master AHB-Lite interconnect.
//   HCLK, HRESETn : bus clock, asynchronous active-low reset
//   bus           : ahblite_bus_fabric_if.slave (core side, slave side, status)
// Address-phase decode against SLV_BASE/SLV_MASK windows (lowest index wins),
// registered data-phase select, response mux, integrated default slave.
// Optional watchdog: define AHB_FABRIC_WATCHDOG_EN to terminate transfers
// stalled for TIMEOUT_CYCLES cycles with an ERROR and a WDT_ERR pulse.
module ahblite_bus_fabric
    import ahblite_fabric_pkg::*;
#(
    parameter int unsigned                 NUM_SLAVES     = 7,
    parameter int unsigned                 DATA_W         = 32,
    parameter logic [NUM_SLAVES*32-1:0]    SLV_BASE       = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0]    SLV_MASK       = {NUM_SLAVES{32'hF000_0000}},
    parameter int unsigned                 TIMEOUT_CYCLES = 256
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahblite_bus_fabric_if.slave bus
);

    // sel_q bit NUM_SLAVES is the default slave; all-zero means "none".
    localparam int unsigned DefIdx = NUM_SLAVES;

    logic [NUM_SLAVES-1:0] hsel;
    logic                  hit;
    logic [NUM_SLAVES:0]   sel_q, sel_d;
    logic                  hready, hresp;
    logic [DATA_W-1:0]     hrdata;
    logic                  accept;
    logic                  wdt_force;
    logic                  ds_busy, ds_ready, ds_resp, ds_dec_err, ds_wdt_err;

    // Address decode: scan high to low so the lowest matching index wins.
    always_comb begin
        hsel = '0;
        hit  = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hsel    = '0;
                hsel[i] = 1'b1;
                hit     = 1'b1;
            end
        end
    end

    assign accept = hready & bus.HTRANS[1];

    always_comb begin
        sel_d = sel_q;
        if (wdt_force) begin
            sel_d = '0;
        end else if (hready) begin
            if (bus.HTRANS[1]) begin
                sel_d = hit ? {1'b0, hsel} : {1'b1, {NUM_SLAVES{1'b0}}};
            end else begin
                sel_d = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Response mux. A running ERR sequence owns the response even after the
    // watchdog has cleared sel_q.
    always_comb begin
        hready = 1'b1;
        hresp  = RespOkay;
        hrdata = '0;
        if (ds_busy || sel_q[DefIdx]) begin
            hready = ds_ready;
            hresp  = ds_resp;
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (sel_q[i]) begin
                    hready = bus.HREADYOUT_S[i];
                    hresp  = bus.HRESP_S[i];
                    hrdata = bus.HRDATA_S[i*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef AHB_FABRIC_WATCHDOG_EN
    localparam int unsigned    CntW    = wdt_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] wdt_cnt_q;
    logic            stalled;

    assign stalled   = |(sel_q[NUM_SLAVES-1:0] & ~bus.HREADYOUT_S);
    // Fires in the cycle that makes the stall count reach TIMEOUT_CYCLES.
    assign wdt_force = stalled && (wdt_cnt_q == CntLast);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wdt_cnt_q <= '0;
        end else if (hready || wdt_force) begin
            wdt_cnt_q <= '0;
        end else if (stalled) begin
            wdt_cnt_q <= wdt_cnt_q + 1'b1;
        end
    end
`else
    assign wdt_force = 1'b0;
`endif

    ahblite_default_slave u_default_slave (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .err_start (accept & ~hit),
        .force_err (wdt_force),
        .busy      (ds_busy),
        .ready     (ds_ready),
        .resp      (ds_resp),
        .dec_err   (ds_dec_err),
        .wdt_err   (ds_wdt_err)
    );

    assign bus.HREADY      = hready;
    assign bus.HRESP       = hresp;
    assign bus.HRDATA      = hrdata;
    assign bus.HSEL_S      = hsel;
    assign bus.HADDR_S     = bus.HADDR;
    assign bus.HBURST_S    = bus.HBURST;
    assign bus.HMASTLOCK_S = bus.HMASTLOCK;
    assign bus.HPROT_S     = bus.HPROT;
    assign bus.HSIZE_S     = bus.HSIZE;
    assign bus.HTRANS_S    = bus.HTRANS;
    assign bus.HWRITE_S    = bus.HWRITE;
    assign bus.HWDATA_S    = bus.HWDATA;
    assign bus.HREADY_S    = hready;
    assign bus.DEC_ERR     = ds_dec_err;
    // Without the watchdog force_err is tied low, so this stays 0.
    assign bus.WDT_ERR     = ds_wdt_err;

endmodule

// File: tb/tb_ahblite_bus_fabric.sv
// Self-checking bench for ahblite_bus_fabric: table of single transfers plus
// hand-written sequences for error, wait-state, reset and watchdog cases.
module tb_ahblite_bus_fabric;

    localparam int unsigned NS = 3;
    localparam int unsigned DW = 32;
    localparam logic [NS*32-1:0] BASE     = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK     = {3{32'hF000_0000}};
    localparam logic [NS*32-1:0] MASK_OVL = {32'hF000_0000, 32'hF000_0000, 32'h0000_0000};
    localparam logic [NS*DW-1:0] SLV_RD   = {32'h4444_0000, 32'hCAFE_F00D, 32'h1111_0000};

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahblite_bus_fabric_if #(.NUM_SLAVES(NS), .DATA_W(DW)) bus ();
    ahblite_bus_fabric_if #(.NUM_SLAVES(NS), .DATA_W(DW)) bus_ovl ();

    ahblite_bus_fabric #(
        .NUM_SLAVES     (NS),
        .DATA_W         (DW),
        .SLV_BASE       (BASE),
        .SLV_MASK       (MASK),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    ahblite_bus_fabric #(
        .NUM_SLAVES     (NS),
        .DATA_W         (DW),
        .SLV_BASE       (BASE),
        .SLV_MASK       (MASK_OVL),
        .TIMEOUT_CYCLES (8)
    ) dut_ovl (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus_ovl)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  slv_resp;
        logic [2:0]  exp_hsel;
        logic        exp_ready;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{32'h2000_0010, T_NONSEQ, 3'b000, 3'b010, 1'b1, 1'b0, 32'hCAFE_F00D};
        vecs[1] = '{32'h0000_0004, T_NONSEQ, 3'b000, 3'b001, 1'b1, 1'b0, 32'h1111_0000};
        vecs[2] = '{32'h4000_0008, T_SEQ,    3'b000, 3'b100, 1'b1, 1'b0, 32'h4444_0000};
        vecs[3] = '{32'h4FFF_FFFC, T_NONSEQ, 3'b100, 3'b100, 1'b1, 1'b1, 32'h4444_0000};
        vecs[4] = '{32'h2000_0000, T_IDLE,   3'b000, 3'b010, 1'b1, 1'b0, 32'h0000_0000};
        vecs[5] = '{32'h0000_0000, T_BUSY,   3'b000, 3'b001, 1'b1, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'h9000_0000, T_IDLE,   3'b000, 3'b000, 1'b1, 1'b0, 32'h0000_0000};

        bus.HADDR       = 32'h2000_0000;
        bus.HBURST      = 3'b000;
        bus.HMASTLOCK   = 1'b0;
        bus.HPROT       = 4'b0011;
        bus.HSIZE       = 3'b010;
        bus.HTRANS      = T_IDLE;
        bus.HWRITE      = 1'b0;
        bus.HWDATA      = 32'h0;
        bus.HREADYOUT_S = 3'b111;
        bus.HRESP_S     = 3'b000;
        bus.HRDATA_S    = SLV_RD;

        bus_ovl.HADDR       = 32'h0;
        bus_ovl.HBURST      = 3'b000;
        bus_ovl.HMASTLOCK   = 1'b0;
        bus_ovl.HPROT       = 4'b0011;
        bus_ovl.HSIZE       = 3'b010;
        bus_ovl.HTRANS      = T_IDLE;
        bus_ovl.HWRITE      = 1'b0;
        bus_ovl.HWDATA      = 32'h0;
        bus_ovl.HREADYOUT_S = 3'b111;
        bus_ovl.HRESP_S     = 3'b000;
        bus_ovl.HRDATA_S    = SLV_RD;

        // Reset values; HSEL_S follows decode even in reset.
        repeat (2) @(negedge clk);
        #1;
        check("rst_hready", bus.HREADY, 1'b1);
        check("rst_hresp", bus.HRESP, 1'b0);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        check("rst_dec_err", bus.DEC_ERR, 1'b0);
        check("rst_wdt_err", bus.WDT_ERR, 1'b0);
        check("rst_hsel", bus.HSEL_S, 3'b010);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: address phase then one data-phase cycle per entry.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            bus.HADDR   = vecs[v].addr;
            bus.HTRANS  = vecs[v].trans;
            bus.HRESP_S = vecs[v].slv_resp;
            #1;
            check($sformatf("v%0d_hsel", v), bus.HSEL_S, vecs[v].exp_hsel);
            check($sformatf("v%0d_haddr_s", v), bus.HADDR_S, vecs[v].addr);
            @(negedge clk);
            bus.HTRANS = T_IDLE;
            #1;
            check($sformatf("v%0d_hready", v), bus.HREADY, vecs[v].exp_ready);
            check($sformatf("v%0d_hresp", v), bus.HRESP, vecs[v].exp_resp);
            check($sformatf("v%0d_hrdata", v), bus.HRDATA, vecs[v].exp_rdata);
        end
        bus.HRESP_S = 3'b000;

        // Unmapped write: one wait state, two cycles of ERROR, DEC_ERR in the second.
        @(negedge clk);
        bus.HADDR  = 32'h9000_0000;
        bus.HTRANS = T_NONSEQ;
        bus.HWRITE = 1'b1;
        bus.HWDATA = 32'h1234_5678;
        #1;
        check("um_hsel", bus.HSEL_S, 3'b000);
        check("um_hwdata_s", bus.HWDATA_S, 32'h1234_5678);
        @(negedge clk);
        bus.HTRANS = T_IDLE;
        bus.HWRITE = 1'b0;
        #1;
        check("um_c1_hready", bus.HREADY, 1'b0);
        check("um_c1_hresp", bus.HRESP, 1'b1);
        check("um_c1_dec_err", bus.DEC_ERR, 1'b0);
        @(negedge clk);
        #1;
        check("um_c2_hready", bus.HREADY, 1'b1);
        check("um_c2_hresp", bus.HRESP, 1'b1);
        check("um_c2_dec_err", bus.DEC_ERR, 1'b1);
        @(negedge clk);
        #1;
        check("um_c3_hready", bus.HREADY, 1'b1);
        check("um_c3_hresp", bus.HRESP, 1'b0);
        check("um_c3_dec_err", bus.DEC_ERR, 1'b0);

        // Back-to-back unmapped: a transfer held during ERR1 is ignored; one
        // accepted in ERR2 restarts the sequence.
        @(negedge clk);
        bus.HADDR  = 32'h9000_0000;
        bus.HTRANS = T_NONSEQ;
        @(negedge clk);
        #1;
        check("bbu_err1_hready", bus.HREADY, 1'b0);
        @(negedge clk);
        bus.HADDR = 32'hA000_0000;
        #1;
        check("bbu_err2_hready", bus.HREADY, 1'b1);
        check("bbu_err2_dec_err", bus.DEC_ERR, 1'b1);
        @(negedge clk);
        bus.HTRANS = T_IDLE;
        #1;
        check("bbu_2nd_err1_hready", bus.HREADY, 1'b0);
        check("bbu_2nd_err1_hresp", bus.HRESP, 1'b1);
        check("bbu_2nd_err1_dec_err", bus.DEC_ERR, 1'b0);
        @(negedge clk);
        #1;
        check("bbu_2nd_err2_dec_err", bus.DEC_ERR, 1'b1);
        @(negedge clk);
        #1;
        check("bbu_done_hresp", bus.HRESP, 1'b0);

        // Slave 0 waits 2 cycles, then slave 2 data follows with no bubble.
        @(negedge clk);
        bus.HADDR       = 32'h0000_0004;
        bus.HTRANS      = T_NONSEQ;
        bus.HREADYOUT_S = 3'b110;
        #1;
        check("ws_hsel0", bus.HSEL_S, 3'b001);
        @(negedge clk);
        bus.HADDR = 32'h4000_0008;
        #1;
        check("ws_w1_hready", bus.HREADY, 1'b0);
        check("ws_w1_hsel2", bus.HSEL_S, 3'b100);
        @(negedge clk);
        #1;
        check("ws_w2_hready", bus.HREADY, 1'b0);
        @(negedge clk);
        bus.HREADYOUT_S = 3'b111;
        #1;
        check("ws_s0_hready", bus.HREADY, 1'b1);
        check("ws_s0_hrdata", bus.HRDATA, 32'h1111_0000);
        @(negedge clk);
        bus.HTRANS = T_IDLE;
        #1;
        check("ws_s2_hready", bus.HREADY, 1'b1);
        check("ws_s2_hrdata", bus.HRDATA, 32'h4444_0000);

        // Overlapping windows: slave 0 mask 0 claims every address.
        begin
            logic [31:0] ovl_addr[3];
            ovl_addr[0] = 32'h2000_0010;
            ovl_addr[1] = 32'h9000_0000;
            ovl_addr[2] = 32'h4000_0000;
            for (int k = 0; k < 3; k++) begin
                bus_ovl.HADDR = ovl_addr[k];
                #1;
                check($sformatf("ovl%0d_hsel", k), bus_ovl.HSEL_S, 3'b001);
            end
        end

        // Reset during a slave 1 wait state.
        @(negedge clk);
        bus.HADDR       = 32'h2000_0000;
        bus.HTRANS      = T_NONSEQ;
        bus.HREADYOUT_S = 3'b101;
        @(negedge clk);
        bus.HTRANS = T_IDLE;
        #1;
        check("rmid_wait_hready", bus.HREADY, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rmid_hready", bus.HREADY, 1'b1);
        check("rmid_hresp", bus.HRESP, 1'b0);
        check("rmid_hrdata", bus.HRDATA, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rmid_after_hready", bus.HREADY, 1'b1);
        bus.HREADYOUT_S = 3'b111;

`ifdef AHB_FABRIC_WATCHDOG_EN
        // Data-phase cycles 0..7 stall, cycle 8 is ERR1, cycle 9 is ERR2.
        @(negedge clk);
        bus.HADDR       = 32'h2000_0000;
        bus.HTRANS      = T_NONSEQ;
        bus.HREADYOUT_S = 3'b101;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.HTRANS = T_IDLE;
            #1;
            check($sformatf("wdt_stall%0d_hready", k), bus.HREADY, 1'b0);
            check($sformatf("wdt_stall%0d_hresp", k), bus.HRESP, 1'b0);
        end
        @(negedge clk);
        #1;
        check("wdt_err1_hready", bus.HREADY, 1'b0);
        check("wdt_err1_hresp", bus.HRESP, 1'b1);
        @(negedge clk);
        bus.HADDR  = 32'h0000_0004;
        bus.HTRANS = T_NONSEQ;
        #1;
        check("wdt_err2_hready", bus.HREADY, 1'b1);
        check("wdt_err2_hresp", bus.HRESP, 1'b1);
        check("wdt_err2_wdt_err", bus.WDT_ERR, 1'b1);
        check("wdt_err2_dec_err", bus.DEC_ERR, 1'b0);
        @(negedge clk);
        bus.HTRANS = T_IDLE;
        #1;
        check("wdt_next_hready", bus.HREADY, 1'b1);
        check("wdt_next_hresp", bus.HRESP, 1'b0);
        check("wdt_next_hrdata", bus.HRDATA, 32'h1111_0000);
        check("wdt_next_wdt_err", bus.WDT_ERR, 1'b0);
        bus.HREADYOUT_S = 3'b111;
`else
        // No watchdog: a stalled slave holds the bus indefinitely.
        @(negedge clk);
        bus.HADDR       = 32'h2000_0000;
        bus.HTRANS      = T_NONSEQ;
        bus.HREADYOUT_S = 3'b101;
        @(negedge clk);
        bus.HTRANS = T_IDLE;
        repeat (20) @(negedge clk);
        #1;
        check("nowdt_stall_hready", bus.HREADY, 1'b0);
        check("nowdt_stall_hresp", bus.HRESP, 1'b0);
        check("nowdt_wdt_err", bus.WDT_ERR, 1'b0);
        bus.HREADYOUT_S = 3'b111;
        #1;
        check("nowdt_release_hready", bus.HREADY, 1'b1);
        check("nowdt_release_hrdata", bus.HRDATA, 32'hCAFE_F00D);
        @(negedge clk);
        #1;
        check("nowdt_idle_hrdata", bus.HRDATA, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
